// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS multicycle control path: sequencer states,
// instruction fields, ALU operations and datapath mux selects.
package mips_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_MEM_ADDR,
        S_MEM_READ,
        S_MEM_WB,
        S_MEM_WRITE,
        S_EXECUTE,
        S_ALU_WB,
        S_BRANCH,
        S_JUMP,
        S_HALT
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] SRCB_RT      = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
        logic [2:0] alu_op;
        logic       halted;
    } ctrl_t;

    // Instruction class dispatch out of DECODE; unknown opcodes park in HALT.
    function automatic state_t decode_dispatch(input logic [5:0] op);
        state_t s;
        case (op)
            OP_LW, OP_SW: s = S_MEM_ADDR;
            OP_RTYPE:     s = S_EXECUTE;
            OP_BEQ:       s = S_BRANCH;
            OP_J:         s = S_JUMP;
            default:      s = S_HALT;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/mips_alu_decode.sv
// R-type function field decode: maps funct to an ALU operation and flags
// encodings the datapath does not implement.
module mips_alu_decode (
    input  logic [5:0] funct,
    output logic [2:0] alu_op,
    output logic       illegal
);
    import mips_pkg::*;

    always_comb begin
        alu_op  = ALU_ADD;
        illegal = 1'b0;
        case (funct)
            FN_ADD:  alu_op = ALU_ADD;
            FN_SUB:  alu_op = ALU_SUB;
            FN_AND:  alu_op = ALU_AND;
            FN_OR:   alu_op = ALU_OR;
            FN_SLT:  alu_op = ALU_SLT;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS sequencer: steps each instruction through fetch, decode,
// execute, memory and write-back, waiting on a shared memory's ready flag.
module mips_multicycle_ctrl (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        run,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        pc_write,
    output logic        i_or_d,
    output logic        mem_read,
    output logic        mem_write,
    output logic        ir_write,
    output logic        reg_dst,
    output logic        mem_to_reg,
    output logic        reg_write,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  pc_source,
    output logic [2:0]  alu_op,
    output logic        halted,
    output logic [31:0] instr_retired
);
    import mips_pkg::*;

    state_t      r_state;
    state_t      w_next;
    ctrl_t       w_ctrl;
    logic [2:0]  w_exec_alu_op;
    logic        w_funct_illegal;
    logic        w_instr_end;
    logic [31:0] r_instr_retired;

    mips_alu_decode u_alu_decode (
        .funct   (funct),
        .alu_op  (w_exec_alu_op),
        .illegal (w_funct_illegal)
    );

    // A store retires on the cycle its write is accepted, not one cycle later.
    assign w_instr_end = (r_state == S_MEM_WB) || (r_state == S_ALU_WB) ||
                         (r_state == S_BRANCH) || (r_state == S_JUMP) ||
                         ((r_state == S_MEM_WRITE) && mem_ready);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:      if (run) w_next = S_FETCH;
            S_FETCH:     if (mem_ready) w_next = S_DECODE;
            S_DECODE:    w_next = decode_dispatch(opcode);
            S_MEM_ADDR:  w_next = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ:  if (mem_ready) w_next = S_MEM_WB;
            S_EXECUTE:   w_next = w_funct_illegal ? S_HALT : S_ALU_WB;
            S_HALT:      w_next = S_HALT;
            S_MEM_WB, S_MEM_WRITE, S_ALU_WB, S_BRANCH, S_JUMP: w_next = r_state;
            default:     w_next = S_IDLE;
        endcase
        if (w_instr_end) begin
            w_next = run ? S_FETCH : S_IDLE;
        end
    end

    always_comb begin
        w_ctrl        = '0;
        w_ctrl.alu_op = ALU_ADD;
        case (r_state)
            S_IDLE: begin
                w_ctrl.alu_op = ALU_AND;
            end
            S_FETCH: begin
                w_ctrl.mem_read  = 1'b1;
                w_ctrl.i_or_d    = 1'b0;
                w_ctrl.alu_src_a = 1'b0;
                w_ctrl.alu_src_b = SRCB_FOUR;
                w_ctrl.pc_source = PCSRC_ALU;
                w_ctrl.ir_write  = mem_ready;
                w_ctrl.pc_write  = mem_ready;
            end
            S_DECODE: begin
                w_ctrl.alu_src_a = 1'b0;
                w_ctrl.alu_src_b = SRCB_IMM_SH2;
            end
            S_MEM_ADDR: begin
                w_ctrl.alu_src_a = 1'b1;
                w_ctrl.alu_src_b = SRCB_IMM;
            end
            S_MEM_READ: begin
                w_ctrl.mem_read = 1'b1;
                w_ctrl.i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                w_ctrl.reg_write  = 1'b1;
                w_ctrl.mem_to_reg = 1'b1;
                w_ctrl.reg_dst    = 1'b0;
            end
            S_MEM_WRITE: begin
                w_ctrl.mem_write = 1'b1;
                w_ctrl.i_or_d    = 1'b1;
            end
            S_EXECUTE: begin
                w_ctrl.alu_src_a = 1'b1;
                w_ctrl.alu_src_b = SRCB_RT;
                w_ctrl.alu_op    = w_exec_alu_op;
            end
            S_ALU_WB: begin
                w_ctrl.reg_write  = 1'b1;
                w_ctrl.reg_dst    = 1'b1;
                w_ctrl.mem_to_reg = 1'b0;
            end
            S_BRANCH: begin
                w_ctrl.alu_src_a = 1'b1;
                w_ctrl.alu_src_b = SRCB_RT;
                w_ctrl.alu_op    = ALU_SUB;
                w_ctrl.pc_source = PCSRC_ALUOUT;
                w_ctrl.pc_write  = zero;
            end
            S_JUMP: begin
                w_ctrl.pc_source = PCSRC_JUMP;
                w_ctrl.pc_write  = 1'b1;
            end
            S_HALT: begin
                w_ctrl.halted = 1'b1;
            end
            default: begin
                w_ctrl.alu_op = ALU_AND;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_instr_retired <= '0;
        end else if (w_instr_end) begin
            r_instr_retired <= r_instr_retired + 32'd1;
        end
    end

    assign pc_write      = w_ctrl.pc_write;
    assign i_or_d        = w_ctrl.i_or_d;
    assign mem_read      = w_ctrl.mem_read;
    assign mem_write     = w_ctrl.mem_write;
    assign ir_write      = w_ctrl.ir_write;
    assign reg_dst       = w_ctrl.reg_dst;
    assign mem_to_reg    = w_ctrl.mem_to_reg;
    assign reg_write     = w_ctrl.reg_write;
    assign alu_src_a     = w_ctrl.alu_src_a;
    assign alu_src_b     = w_ctrl.alu_src_b;
    assign pc_source     = w_ctrl.pc_source;
    assign alu_op        = w_ctrl.alu_op;
    assign halted        = w_ctrl.halted;
    assign instr_retired = r_instr_retired;

endmodule
